qlearn_episode_ctrl: RTL and testbench

//  Sequences one Q-learning episode on the 8x8 grid world (64 states, 4 actions).

---
 rtl/qlearn_episode_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_qlearn_episode_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearn_episode_ctrl.sv
// Q-learning episode sequencer for an 8x8 grid world (64 states, 4 actions).
// Fetches Q(s,*) from the Q-table and picks an action (greedy argmax or
// LFSR-driven exploration). It then moves the agent, fetches Q(s',*) to
// form max Q(s'), and hands one update request per step to the updater.
//
// Handshakes:
//   q_rd_req/q_rd_valid : q_rd_req and q_rd_addr stay stable until a cycle
//                         with q_rd_valid=1; the data is captured on that
//                         edge and q_rd_req falls right after it.
//   upd_valid/upd_ready : upd_valid and the upd_* payload stay stable until
//                         a cycle with upd_ready=1; the transfer happens on
//                         that edge and upd_valid falls right after it.
//   q_rd_req and upd_valid are never high in the same cycle.
module qlearn_episode_ctrl #(
    parameter int          Q_W         = 16,
    parameter logic [5:0]  START_STATE = 6'd0,
    parameter logic [5:0]  GOAL_STATE  = 6'd63,
    parameter logic [7:0]  MAX_STEPS   = 8'd255,
    parameter logic [7:0]  EPS_THRESH  = 8'd26,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             q_rd_req,
    output logic [5:0]       q_rd_addr,
    input  logic             q_rd_valid,
    input  logic [4*Q_W-1:0] q_rd_data,
    output logic             upd_valid,
    input  logic             upd_ready,
    output logic [5:0]       upd_state,
    output logic [1:0]       upd_action,
    output logic [15:0]      upd_reward,
    output logic [Q_W-1:0]   upd_max_next_q,
    output logic [5:0]       cur_state,
    output logic [7:0]       step_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SELECT,
        S_MOVE,
        S_FETCH_NXT,
        S_UPDATE,
        S_FIN
    } state_t;

    state_t                state;
    logic [15:0]           lfsr;
    logic                  lfsr_fb;
    logic signed [Q_W-1:0] q_cur [4];
    logic [5:0]            next_state;

    logic [1:0]            greedy_act;
    logic signed [Q_W-1:0] best_q;
    logic signed [Q_W-1:0] rd_max;
    logic                  explore;
    logic [2:0]            row;
    logic [2:0]            col;
    logic [5:0]            mv_next;
    logic                  mv_off;
    logic [15:0]           mv_reward;
    logic [7:0]            step_inc;

    // Fibonacci feedback for taps 16,14,13,11
    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign explore  = (lfsr[7:0] < EPS_THRESH);
    assign step_inc = step_cnt + 8'd1;
    assign row      = cur_state[5:3];
    assign col      = cur_state[2:0];

    // Signed argmax of the latched Q(s,*); strict compare keeps ties on the lowest index
    always_comb begin
        greedy_act = 2'd0;
        best_q     = q_cur[0];
        for (int i = 1; i < 4; i++) begin
            if (q_cur[i] > best_q) begin
                best_q     = q_cur[i];
                greedy_act = 2'(i);
            end
        end
    end

    // Signed max of the Q-values currently on the read data bus
    always_comb begin
        rd_max = $signed(q_rd_data[0 +: Q_W]);
        for (int i = 1; i < 4; i++) begin
            if ($signed(q_rd_data[i*Q_W +: Q_W]) > rd_max) begin
                rd_max = $signed(q_rd_data[i*Q_W +: Q_W]);
            end
        end
    end

    // Grid move for the chosen action: off-grid moves keep the state and cost -10
    always_comb begin
        mv_next = cur_state;
        mv_off  = 1'b0;
        case (upd_action)
            2'd0: if (row == 3'd0) mv_off = 1'b1; else mv_next = {row - 3'd1, col};
            2'd1: if (row == 3'd7) mv_off = 1'b1; else mv_next = {row + 3'd1, col};
            2'd2: if (col == 3'd0) mv_off = 1'b1; else mv_next = {row, col - 3'd1};
            default: if (col == 3'd7) mv_off = 1'b1; else mv_next = {row, col + 3'd1};
        endcase
        if (mv_off)
            mv_reward = 16'hFFF6;            // -10
        else if (mv_next == GOAL_STATE)
            mv_reward = 16'd100;
        else
            mv_reward = 16'hFFFF;            // -1
    end

    // Episode FSM, LFSR and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lfsr           <= LFSR_SEED;
            busy           <= 1'b0;
            done           <= 1'b0;
            q_rd_req       <= 1'b0;
            q_rd_addr      <= 6'd0;
            upd_valid      <= 1'b0;
            upd_state      <= 6'd0;
            upd_action     <= 2'd0;
            upd_reward     <= 16'd0;
            upd_max_next_q <= '0;
            cur_state      <= START_STATE;
            step_cnt       <= 8'd0;
            next_state     <= 6'd0;
            for (int i = 0; i < 4; i++) q_cur[i] <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_state <= START_STATE;
                        step_cnt  <= 8'd0;
                        busy      <= 1'b1;
                        q_rd_req  <= 1'b1;
                        q_rd_addr <= START_STATE;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (q_rd_valid && q_rd_req) begin
                        for (int i = 0; i < 4; i++) q_cur[i] <= $signed(q_rd_data[i*Q_W +: Q_W]);
                        q_rd_req <= 1'b0;
                        state    <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    upd_state  <= cur_state;
                    upd_action <= explore ? lfsr[9:8] : greedy_act;
                    state      <= S_MOVE;
                end
                S_MOVE: begin
                    next_state <= mv_next;
                    upd_reward <= mv_reward;
                    // The goal is terminal, so its Q-values are never read
                    if (mv_next != GOAL_STATE) begin
                        q_rd_req  <= 1'b1;
                        q_rd_addr <= mv_next;
                    end
                    state <= S_FETCH_NXT;
                end
                S_FETCH_NXT: begin
                    if (next_state == GOAL_STATE) begin
                        upd_max_next_q <= '0;
                        upd_valid      <= 1'b1;
                        state          <= S_UPDATE;
                    end else if (q_rd_valid && q_rd_req) begin
                        upd_max_next_q <= rd_max;
                        q_rd_req       <= 1'b0;
                        upd_valid      <= 1'b1;
                        state          <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (upd_ready) begin
                        upd_valid <= 1'b0;
                        cur_state <= next_state;
                        step_cnt  <= step_inc;
                        if (next_state == GOAL_STATE || step_inc == MAX_STEPS) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FIN;
                        end else begin
                            q_rd_req  <= 1'b1;
                            q_rd_addr <= next_state;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// Directed bench for qlearn_episode_ctrl. Three instances:
//   A: greedy (EPS_THRESH=0), start 0, MAX_STEPS=4
//   B: greedy, start 62 (one step from the goal)
//   C: always explore (EPS_THRESH=255), start 0
module tb_qlearn_episode_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---- instance A
    logic        a_start = 1'b0, a_rd_valid = 1'b0, a_upd_ready = 1'b0;
    logic [63:0] a_rd_data = 64'd0;
    logic        a_busy, a_done, a_rd_req, a_upd_valid;
    logic [5:0]  a_rd_addr, a_upd_state, a_cur_state;
    logic [1:0]  a_upd_action;
    logic [15:0] a_upd_reward, a_upd_mq;
    logic [7:0]  a_step_cnt;

    // ---- instance B
    logic        b_start = 1'b0, b_rd_valid = 1'b0, b_upd_ready = 1'b0;
    logic [63:0] b_rd_data = 64'd0;
    logic        b_busy, b_done, b_rd_req, b_upd_valid;
    logic [5:0]  b_rd_addr, b_upd_state, b_cur_state;
    logic [1:0]  b_upd_action;
    logic [15:0] b_upd_reward, b_upd_mq;
    logic [7:0]  b_step_cnt;

    // ---- instance C
    logic        c_start = 1'b0, c_rd_valid = 1'b0, c_upd_ready = 1'b0;
    logic [63:0] c_rd_data = 64'd0;
    logic        c_busy, c_done, c_rd_req, c_upd_valid;
    logic [5:0]  c_rd_addr, c_upd_state, c_cur_state;
    logic [1:0]  c_upd_action;
    logic [15:0] c_upd_reward, c_upd_mq;
    logic [7:0]  c_step_cnt;

    qlearn_episode_ctrl #(.EPS_THRESH(8'd0), .MAX_STEPS(8'd4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .q_rd_req(a_rd_req), .q_rd_addr(a_rd_addr), .q_rd_valid(a_rd_valid),
        .q_rd_data(a_rd_data), .upd_valid(a_upd_valid), .upd_ready(a_upd_ready),
        .upd_state(a_upd_state), .upd_action(a_upd_action), .upd_reward(a_upd_reward),
        .upd_max_next_q(a_upd_mq), .cur_state(a_cur_state), .step_cnt(a_step_cnt)
    );

    qlearn_episode_ctrl #(.EPS_THRESH(8'd0), .START_STATE(6'd62)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .q_rd_req(b_rd_req), .q_rd_addr(b_rd_addr), .q_rd_valid(b_rd_valid),
        .q_rd_data(b_rd_data), .upd_valid(b_upd_valid), .upd_ready(b_upd_ready),
        .upd_state(b_upd_state), .upd_action(b_upd_action), .upd_reward(b_upd_reward),
        .upd_max_next_q(b_upd_mq), .cur_state(b_cur_state), .step_cnt(b_step_cnt)
    );

    qlearn_episode_ctrl #(.EPS_THRESH(8'd255)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .busy(c_busy), .done(c_done),
        .q_rd_req(c_rd_req), .q_rd_addr(c_rd_addr), .q_rd_valid(c_rd_valid),
        .q_rd_data(c_rd_data), .upd_valid(c_upd_valid), .upd_ready(c_upd_ready),
        .upd_state(c_upd_state), .upd_action(c_upd_action), .upd_reward(c_upd_reward),
        .upd_max_next_q(c_upd_mq), .cur_state(c_cur_state), .step_cnt(c_step_cnt)
    );

    // ---- monitors: done pulses and read/update overlap
    int a_done_cnt = 0;
    int overlap_cnt = 0;
    int a_unstable = 0;

    always @(posedge clk) begin
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if ((a_rd_req && a_upd_valid) || (b_rd_req && b_upd_valid) || (c_rd_req && c_upd_valid))
            overlap_cnt <= overlap_cnt + 1;
    end

    // ---- driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_start = 1'b0; a_rd_valid = 1'b0; a_upd_ready = 1'b0;
        b_start = 1'b0; b_rd_valid = 1'b0; b_upd_ready = 1'b0;
        c_start = 1'b0; c_rd_valid = 1'b0; c_upd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic a_start_ep();
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
    endtask

    // Waits for a read request, holds off q_rd_valid for lat cycles, then answers
    task automatic a_serve(input logic [63:0] data, input int lat, output logic [5:0] addr);
        int n = 0;
        while (!a_rd_req && n < 50) begin cyc(); n++; end
        checks++;
        if (!a_rd_req) begin
            errors++;
            $display("FAIL rd_timeout: q_rd_req=%0b after %0d cycles, required 1", a_rd_req, n);
            addr = 6'h3f;
            return;
        end
        addr = a_rd_addr;
        for (int i = 0; i < lat; i++) begin
            cyc();
            if (!a_rd_req || a_rd_addr !== addr || a_upd_valid) a_unstable++;
        end
        a_rd_data  = data;
        a_rd_valid = 1'b1;
        cyc();
        a_rd_valid = 1'b0;
        if (a_rd_req) a_unstable++;
    endtask

    // Waits for an update request, holds off upd_ready for lat cycles, then accepts
    task automatic a_take(input int lat, output logic [5:0] s, output logic [1:0] act,
                          output logic [15:0] r, output logic [15:0] mq);
        int n = 0;
        while (!a_upd_valid && n < 50) begin cyc(); n++; end
        checks++;
        if (!a_upd_valid) begin
            errors++;
            $display("FAIL upd_timeout: upd_valid=%0b after %0d cycles, required 1", a_upd_valid, n);
            s = 6'h3f; act = 2'd3; r = 16'hdead; mq = 16'hdead;
            return;
        end
        s = a_upd_state; act = a_upd_action; r = a_upd_reward; mq = a_upd_mq;
        for (int i = 0; i < lat; i++) begin
            cyc();
            if (!a_upd_valid || a_upd_state !== s || a_upd_action !== act ||
                a_upd_reward !== r || a_upd_mq !== mq || a_rd_req) a_unstable++;
        end
        a_upd_ready = 1'b1;
        cyc();
        a_upd_ready = 1'b0;
        if (a_upd_valid) a_unstable++;
    endtask

    // ---- scenarios
    task automatic test_reset();
        logic [5:0] ad; logic [5:0] s; logic [1:0] act; logic [15:0] r, mq;
        int dc;
        // held in reset from time 0
        cyc();
        checks++;
        if ({a_busy, a_done, a_rd_req, a_rd_addr, a_upd_valid, a_upd_state, a_upd_action,
             a_upd_reward, a_upd_mq, a_step_cnt, a_cur_state} !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b req=%0b upd_valid=%0b cur=%0d, required all 0",
                     a_busy, a_done, a_rd_req, a_upd_valid, a_cur_state);
        end
        checks++;
        if (b_cur_state !== 6'd62) begin
            errors++;
            $display("FAIL reset_start_state: cur_state=%0d, required 62", b_cur_state);
        end
        do_reset();
        // run into UPDATE and stall there
        a_start_ep();
        a_serve({16'hFFFD, 16'd9, 16'd9, 16'd5}, 0, ad);
        a_serve({16'd3, 16'hFFFE, 16'd7, 16'd1}, 0, ad);
        for (int n = 0; n < 20 && !a_upd_valid; n++) cyc();
        checks++;
        if (a_upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_update: upd_valid=%0b, required 1", a_upd_valid);
        end
        dc = a_done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_busy, a_done, a_rd_req, a_rd_addr, a_upd_valid, a_upd_state, a_upd_action,
             a_upd_reward, a_upd_mq, a_step_cnt, a_cur_state} !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_update: busy=%0b req=%0b upd_valid=%0b act=%0d rew=%h mq=%h cur=%0d, required all 0",
                     a_busy, a_rd_req, a_upd_valid, a_upd_action, a_upd_reward, a_upd_mq, a_cur_state);
        end
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (5) cyc();
        checks++;
        if (a_done_cnt !== dc || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done pulses=%0d busy=%0b, required %0d and 0", a_done_cnt, a_busy, dc);
        end
        s = 0; act = 0; r = 0; mq = 0;
    endtask

    task automatic test_greedy();
        logic [5:0] ad; logic [5:0] s; logic [1:0] act; logic [15:0] r, mq;
        do_reset();
        a_start_ep();
        checks++;
        if (a_busy !== 1'b1 || a_step_cnt !== 8'd0) begin
            errors++;
            $display("FAIL greedy_busy: busy=%0b step=%0d, required 1 and 0", a_busy, a_step_cnt);
        end
        // Q(0)={5,9,9,-3}: tie between a1 and a2 goes to a1 (down)
        a_serve({16'hFFFD, 16'd9, 16'd9, 16'd5}, 0, ad);
        checks++;
        if (ad !== 6'd0) begin
            errors++;
            $display("FAIL greedy_addr0: addr=%0d, required 0", ad);
        end
        // Q(8)={1,7,-2,3} -> max 7
        a_serve({16'd3, 16'hFFFE, 16'd7, 16'd1}, 0, ad);
        checks++;
        if (ad !== 6'd8) begin
            errors++;
            $display("FAIL greedy_addr_next: addr=%0d, required 8", ad);
        end
        a_take(0, s, act, r, mq);
        checks++;
        if (s !== 6'd0 || act !== 2'd1 || r !== 16'hFFFF || mq !== 16'd7) begin
            errors++;
            $display("FAIL greedy_payload: s=%0d a=%0d r=%h mq=%h, required 0 1 ffff 0007", s, act, r, mq);
        end
        checks++;
        if (a_cur_state !== 6'd8 || a_step_cnt !== 8'd1) begin
            errors++;
            $display("FAIL greedy_state: cur=%0d step=%0d, required 8 1", a_cur_state, a_step_cnt);
        end
    endtask

    task automatic test_wall();
        logic [5:0] ad; logic [5:0] s; logic [1:0] act; logic [15:0] r, mq;
        do_reset();
        a_start_ep();
        // Q(0)={20,-5,3,20}: tie a0/a3 goes to a0 (up) -> off grid
        a_serve({16'd20, 16'd3, 16'hFFFB, 16'd20}, 0, ad);
        // Q(0) again, all negative {-4,-8,-2,-6} -> max -2
        a_serve({16'hFFFA, 16'hFFFE, 16'hFFF8, 16'hFFFC}, 0, ad);
        checks++;
        if (ad !== 6'd0) begin
            errors++;
            $display("FAIL wall_addr_next: addr=%0d, required 0", ad);
        end
        a_take(0, s, act, r, mq);
        checks++;
        if (s !== 6'd0 || act !== 2'd0 || r !== 16'hFFF6 || mq !== 16'hFFFE) begin
            errors++;
            $display("FAIL wall_payload: s=%0d a=%0d r=%h mq=%h, required 0 0 fff6 fffe", s, act, r, mq);
        end
        checks++;
        if (a_cur_state !== 6'd0 || a_step_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wall_state: cur=%0d step=%0d, required 0 1", a_cur_state, a_step_cnt);
        end
    endtask

    task automatic test_goal();
        int n;
        int extra_rd = 0;
        do_reset();
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        n = 0;
        while (!b_rd_req && n < 50) begin cyc(); n++; end
        checks++;
        if (b_rd_req !== 1'b1 || b_rd_addr !== 6'd62) begin
            errors++;
            $display("FAIL goal_first_read: req=%0b addr=%0d, required 1 62", b_rd_req, b_rd_addr);
        end
        // Q(62)={3,2,1,50} -> right
        b_rd_data  = {16'd50, 16'd1, 16'd2, 16'd3};
        b_rd_valid = 1'b1;
        cyc();
        b_rd_valid = 1'b0;
        n = 0;
        while (!b_upd_valid && n < 20) begin
            if (b_rd_req) extra_rd++;
            cyc();
            n++;
        end
        checks++;
        if (extra_rd !== 0 || b_upd_valid !== 1'b1) begin
            errors++;
            $display("FAIL goal_no_second_read: extra reads=%0d upd_valid=%0b, required 0 1", extra_rd, b_upd_valid);
        end
        checks++;
        if (b_upd_state !== 6'd62 || b_upd_action !== 2'd3 || b_upd_reward !== 16'd100 || b_upd_mq !== 16'd0) begin
            errors++;
            $display("FAIL goal_payload: s=%0d a=%0d r=%h mq=%h, required 62 3 0064 0000",
                     b_upd_state, b_upd_action, b_upd_reward, b_upd_mq);
        end
        b_upd_ready = 1'b1;
        cyc();
        b_upd_ready = 1'b0;
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0 || b_cur_state !== 6'd63 || b_step_cnt !== 8'd1) begin
            errors++;
            $display("FAIL goal_done: done=%0b busy=%0b cur=%0d step=%0d, required 1 0 63 1",
                     b_done, b_busy, b_cur_state, b_step_cnt);
        end
        cyc();
        checks++;
        if (b_done !== 1'b0 || b_cur_state !== 6'd63) begin
            errors++;
            $display("FAIL goal_done_pulse: done=%0b cur=%0d, required 0 63", b_done, b_cur_state);
        end
    endtask

    task automatic test_stall();
        logic [5:0] ad0, ad1; logic [5:0] s; logic [1:0] act; logic [15:0] r, mq;
        do_reset();
        a_unstable = 0;
        a_start_ep();
        // Q(0)={0,0,0,4} -> right to 1; Q(1)={0,16,0,0} -> max 16
        a_serve({16'd4, 16'd0, 16'd0, 16'd0}, 5, ad0);
        a_serve({16'd0, 16'd0, 16'h0010, 16'd0}, 5, ad1);
        a_take(3, s, act, r, mq);
        checks++;
        if (a_unstable !== 0) begin
            errors++;
            $display("FAIL stall_stable: unstable cycles=%0d, required 0", a_unstable);
        end
        checks++;
        if (ad0 !== 6'd0 || ad1 !== 6'd1 || s !== 6'd0 || act !== 2'd3 || r !== 16'hFFFF || mq !== 16'h0010) begin
            errors++;
            $display("FAIL stall_payload: addr0=%0d addr1=%0d s=%0d a=%0d r=%h mq=%h, required 0 1 0 3 ffff 0010",
                     ad0, ad1, s, act, r, mq);
        end
    endtask

    task automatic test_max_steps();
        logic [5:0] ad; logic [5:0] s; logic [1:0] act; logic [15:0] r, mq;
        int dc, n, bad, extra;
        do_reset();
        dc  = a_done_cnt;
        bad = 0;
        a_start_ep();
        for (int k = 0; k < 4; k++) begin
            a_serve({16'd0, 16'd0, 16'd0, 16'd9}, 0, ad);
            a_serve({16'd4, 16'd3, 16'd2, 16'd1}, 0, ad);
            a_take(0, s, act, r, mq);
            if (s !== 6'd0 || act !== 2'd0 || r !== 16'hFFF6 || mq !== 16'd4) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL max_payloads: bad updates=%0d, required 0", bad);
        end
        n = 0;
        while (!a_done && n < 10) begin cyc(); n++; end
        checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL max_done: done=%0b busy=%0b, required 1 0", a_done, a_busy);
        end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (a_rd_req || a_upd_valid || a_busy) extra++;
        end
        checks++;
        if (a_step_cnt !== 8'd4 || a_cur_state !== 6'd0 || a_done_cnt !== dc + 1 || extra !== 0) begin
            errors++;
            $display("FAIL max_final: step=%0d cur=%0d done pulses=%0d activity=%0d, required 4 0 %0d 0",
                     a_step_cnt, a_cur_state, a_done_cnt - dc, extra, 1);
        end
        // start ignored while busy: a second start pulse mid-episode must not reset step_cnt
        a_start_ep();
        a_serve({16'd0, 16'd0, 16'd0, 16'd9}, 0, ad);
        a_serve({16'd4, 16'd3, 16'd2, 16'd1}, 0, ad);
        a_take(0, s, act, r, mq);
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
        checks++;
        if (a_step_cnt !== 8'd1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: step=%0d busy=%0b, required 1 1", a_step_cnt, a_busy);
        end
    endtask

    task automatic test_explore();
        int cnt[4];
        int total = 0;
        int lat_left = 0;
        int n = 0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        do_reset();
        c_upd_ready = 1'b1;
        c_start     = 1'b1;
        while (total < 1000 && n < 40000) begin
            cyc();
            n++;
            if (c_rd_valid) begin
                c_rd_valid = 1'b0;
            end else if (c_rd_req) begin
                if (lat_left == 0) begin
                    c_rd_data  = {$urandom, $urandom};
                    c_rd_valid = 1'b1;
                    lat_left   = $urandom_range(0, 2);
                end else begin
                    lat_left--;
                end
            end
            if (c_upd_valid) begin
                cnt[c_upd_action]++;
                total++;
            end
        end
        c_start = 1'b0;
        checks++;
        if (total < 1000) begin
            errors++;
            $display("FAIL explore_timeout: updates=%0d, required 1000", total);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] < 200 || cnt[i] > 300) begin
                errors++;
                $display("FAIL explore_freq_a%0d: count=%0d of %0d, required 200..300", i, cnt[i], total);
            end
        end
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_wall();
        test_goal();
        test_stall();
        test_max_steps();
        test_explore();
        checks++;
        if (overlap_cnt !== 0) begin
            errors++;
            $display("FAIL req_upd_overlap: cycles=%0d, required 0", overlap_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
